// File: rtl/door_pkg.sv
// Shared definitions for the sliding-door sequencer.
//
// Contents:
//   door_state_e      state register encoding (codes are visible on state_o)
//   TARGET_OPEN/CLOSE direction taken when the motor dead-time ends
//   DEF_*             default timing parameters for door_sequencer
//   SYNC_*            bit positions of the synchronised input bus
package door_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED    = 3'd0,
        ST_DEAD      = 3'd1,
        ST_OPENING   = 3'd2,
        ST_OPEN_HOLD = 3'd3,
        ST_CLOSING   = 3'd4,
        ST_ESTOP     = 3'd5,
        ST_FAULT     = 3'd6,
        ST_ILLEGAL   = 3'd7   // never entered on purpose; recovers to FAULT
    } door_state_e;

    localparam logic TARGET_OPEN  = 1'b1;
    localparam logic TARGET_CLOSE = 1'b0;

    localparam int DEF_HOLD_CYCLES = 1000;
    localparam int DEF_TRAVEL_MAX  = 4000;
    localparam int DEF_DEAD_CYCLES = 8;
    localparam int DEF_CNT_W       = 16;

    // Synchronised input bus layout: {se, sen, la, lc, fault_clr}
    localparam int SYNC_W   = 5;
    localparam int SYNC_SE  = 4;
    localparam int SYNC_SEN = 3;
    localparam int SYNC_LA  = 2;
    localparam int SYNC_LC  = 1;
    localparam int SYNC_CLR = 0;

endpackage

// File: rtl/door_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous inputs.
// Each bit is synchronised on its own; no cross-bit coherency is implied.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset, clears both stages to 0
//   ena    when 0 both stages hold their contents
//   d      raw asynchronous inputs
//   q      synchronised outputs, two enabled cycles behind d
module door_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others; with blocking '=' the two
    // stages would collapse into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else if (ena) begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/door_sequencer.sv
// Timed motion controller for a single sliding-door motor.
//
// Sequences a full door cycle: open on presence, hold open, auto-close,
// reverse on obstruction, enforce a motor dead-time before every start,
// fault on travel timeout or contradictory limit switches, and stop on
// emergency. Outputs are Moore-decoded from the state register, so the
// two motor drives can never be active together.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ena          0 freezes state, counter and synchronisers
//   sen_i        presence / obstruction sensor
//   se_i         emergency stop
//   la_i         open limit switch
//   lc_i         closed limit switch
//   fault_clr_i  clears a latched fault (ignored while se is active)
//   ma_o         motor open drive
//   mc_o         motor close drive
//   state_o      current state code (door_state_e)
//   fault_o      1 while in FAULT
//   busy_o       1 while in DEAD, OPENING or CLOSING
module door_sequencer
    import door_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int TRAVEL_MAX  = DEF_TRAVEL_MAX,
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       sen_i,
    input  logic       se_i,
    input  logic       la_i,
    input  logic       lc_i,
    input  logic       fault_clr_i,
    output logic       ma_o,
    output logic       mc_o,
    output logic [2:0] state_o,
    output logic       fault_o,
    output logic       busy_o
);

    // Counter values on the final cycle of each timed phase.
    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic [SYNC_W-1:0] pins_sync;

    door_sync #(.WIDTH(SYNC_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .d     ({se_i, sen_i, la_i, lc_i, fault_clr_i}),
        .q     (pins_sync)
    );

    logic se, sen, la, lc, clr;
    assign se  = pins_sync[SYNC_SE];
    assign sen = pins_sync[SYNC_SEN];
    assign la  = pins_sync[SYNC_LA];
    assign lc  = pins_sync[SYNC_LC];
    assign clr = pins_sync[SYNC_CLR];

    // ------------------------------------------------------------------
    // State, phase counter and direction target
    // ------------------------------------------------------------------
    door_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             target_q, target_d;
    logic             cnt_restart;
    logic             in_motion;

    // DEAD counts as motion: the motor is about to start and the limit
    // switches must already be consistent.
    assign in_motion = (state_q == ST_DEAD) || (state_q == ST_OPENING) ||
                       (state_q == ST_CLOSING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_CLOSED;
            cnt_q    <= '0;
            target_q <= TARGET_CLOSE;
        end else if (ena) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

    // Next-state logic. The if-chain encodes the priority
    // se > (la & lc) > timeout > limit switch > sen.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the branches can leave one unassigned and infer a latch.
        state_d     = state_q;
        target_d    = target_q;
        cnt_restart = 1'b0;

        if (state_q == ST_ILLEGAL) begin
            state_d = ST_FAULT;
        end else if (state_q == ST_FAULT) begin
            // Sticky: only an explicit clear outside emergency leaves it.
            if (clr && !se) begin
                state_d = ST_CLOSED;
            end
        end else if (se) begin
            state_d = ST_ESTOP;
        end else if (in_motion && la && lc) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_CLOSED: begin
                    if (sen) begin
                        state_d  = ST_DEAD;
                        target_d = TARGET_OPEN;
                    end else if (!lc) begin
                        // Door drifted off the closed switch: pull it shut.
                        state_d  = ST_DEAD;
                        target_d = TARGET_CLOSE;
                    end
                end
                ST_DEAD: begin
                    if (cnt_q == DEAD_LAST) begin
                        state_d = (target_q == TARGET_OPEN) ? ST_OPENING
                                                            : ST_CLOSING;
                    end
                end
                ST_OPENING: begin
                    if (cnt_q == TRAVEL_LAST) begin
                        state_d = ST_FAULT;
                    end else if (la) begin
                        state_d = ST_OPEN_HOLD;
                    end
                end
                ST_OPEN_HOLD: begin
                    // Each presence restarts the hold time from zero.
                    if (sen) begin
                        cnt_restart = 1'b1;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d  = ST_DEAD;
                        target_d = TARGET_CLOSE;
                    end
                end
                ST_CLOSING: begin
                    if (cnt_q == TRAVEL_LAST) begin
                        state_d = ST_FAULT;
                    end else if (lc) begin
                        state_d = ST_CLOSED;
                    end else if (sen) begin
                        // Obstruction: reverse through the dead-time.
                        state_d  = ST_DEAD;
                        target_d = TARGET_OPEN;
                    end
                end
                ST_ESTOP: begin
                    // se is already known to be low on this path.
                    state_d = ST_CLOSED;
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end
    end

    // Phase counter: restarts on every state change, saturates otherwise.
    always_comb begin
        if ((state_d != state_q) || cnt_restart) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    assign ma_o    = (state_q == ST_OPENING);
    assign mc_o    = (state_q == ST_CLOSING);
    assign fault_o = (state_q == ST_FAULT);
    assign busy_o  = in_motion;
    assign state_o = state_q;

endmodule

// File: tb/tb_door_sequencer.sv
// Self-checking bench for door_sequencer with short timing parameters.
// A behavioural model tracks the door phase and time spent in it; the
// synchronisers are modelled as a two-deep delay queue of pin samples.
module tb_door_sequencer;

    localparam int HOLD   = 10;
    localparam int TRAVEL = 50;
    localparam int DEAD   = 4;

    // Expected output vectors {fault, busy, mc, ma, state[2:0]}
    localparam logic [6:0] V_CLOSED  = 7'b0000000;
    localparam logic [6:0] V_DEAD    = 7'b0100001;
    localparam logic [6:0] V_OPENING = 7'b0101010;
    localparam logic [6:0] V_HOLD    = 7'b0000011;
    localparam logic [6:0] V_CLOSING = 7'b0110100;
    localparam logic [6:0] V_ESTOP   = 7'b0000101;
    localparam logic [6:0] V_FAULT   = 7'b1000110;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       sen_i = 1'b0, se_i = 1'b0, la_i = 1'b0, lc_i = 1'b1;
    logic       fault_clr_i = 1'b0;
    logic       ma_o, mc_o, fault_o, busy_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;

    door_sequencer #(
        .HOLD_CYCLES (HOLD),
        .TRAVEL_MAX  (TRAVEL),
        .DEAD_CYCLES (DEAD),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .sen_i       (sen_i),
        .se_i        (se_i),
        .la_i        (la_i),
        .lc_i        (lc_i),
        .fault_clr_i (fault_clr_i),
        .ma_o        (ma_o),
        .mc_o        (mc_o),
        .state_o     (state_o),
        .fault_o     (fault_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: phase number, cycles spent in it, pending direction
    // ------------------------------------------------------------------
    int         m_state;
    int         m_age;
    bit         m_go_open;
    logic [4:0] m_pipe[$];

    task automatic model_reset();
        m_state   = 0;
        m_age     = 0;
        m_go_open = 1'b0;
        m_pipe.delete();
        m_pipe.push_back(5'b0);
        m_pipe.push_back(5'b0);
    endtask

    task automatic model_clock();
        logic [4:0] seen;
        logic se, sen, la, lc, clr;
        int  nxt;
        bit  restart;
        if (!ena) return;
        seen = m_pipe.pop_front();
        m_pipe.push_back({se_i, sen_i, la_i, lc_i, fault_clr_i});
        {se, sen, la, lc, clr} = seen;
        nxt = m_state;
        restart = 1'b0;
        if (m_state == 6) begin
            if (clr && !se) nxt = 0;
        end else if (se) begin
            nxt = 5;
        end else if ((m_state == 1 || m_state == 2 || m_state == 4) && la && lc) begin
            nxt = 6;
        end else begin
            case (m_state)
                0: if (sen) begin nxt = 1; m_go_open = 1'b1; end
                   else if (!lc) begin nxt = 1; m_go_open = 1'b0; end
                1: if (m_age + 1 == DEAD) nxt = m_go_open ? 2 : 4;
                2: if (m_age + 1 == TRAVEL) nxt = 6; else if (la) nxt = 3;
                3: if (sen) restart = 1'b1;
                   else if (m_age + 1 == HOLD) begin nxt = 1; m_go_open = 1'b0; end
                4: if (m_age + 1 == TRAVEL) nxt = 6;
                   else if (lc) nxt = 0;
                   else if (sen) begin nxt = 1; m_go_open = 1'b1; end
                5: nxt = 0;
                default: nxt = 6;
            endcase
        end
        if (nxt != m_state || restart) m_age = 0;
        else if (m_age < 65535) m_age++;
        m_state = nxt;
    endtask

    function automatic logic [6:0] exp_vec();
        logic busy;
        busy = (m_state == 1) || (m_state == 2) || (m_state == 4);
        return {m_state == 6, busy, m_state == 4, m_state == 2, 3'(m_state)};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {fault_o, busy_o, mc_o, ma_o, state_o};
    endfunction

    // One clock: model follows the same edge, outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_clock();
        #1;
    endtask

    // Reset, then let the door settle in CLOSED with lc held high.
    task automatic reset_settle();
        ena = 1'b1; se_i = 1'b0; sen_i = 1'b0; la_i = 1'b0; lc_i = 1'b1;
        fault_clr_i = 1'b0;
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        repeat (20) step();
    endtask

    // Single-cycle presence pulse; door reaches OPENING 7 cycles after it.
    task automatic go_opening();
        sen_i = 1'b1;
        step();
        sen_i = 1'b0;
        repeat (6) step();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        ena = 1'b1; se_i = 1'b0; sen_i = 1'b0; la_i = 1'b0; lc_i = 1'b1;
        fault_clr_i = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== V_CLOSED) $display("FAIL reset_async: dut=%b expected=%b", dut_vec(), V_CLOSED);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (dut_vec() !== V_CLOSED) $display("FAIL reset_held: dut=%b expected=%b", dut_vec(), V_CLOSED);
        else n_pass++;
        rst_n = 1'b1;
        // Synchronisers leave reset at 0, so lc reads low for two cycles
        // and the door performs one short re-close before idling.
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL reset_startup[%0d]: dut=%b model=%b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        for (int i = 0; i < 100; i++) begin
            step();
            n_checks++;
            if (state_o !== 3'd0 || ma_o !== 1'b0 || mc_o !== 1'b0)
                $display("FAIL reset_idle[%0d]: state=%0d ma=%b mc=%b expected 0/0/0", i, state_o, ma_o, mc_o);
            else n_pass++;
        end
    endtask

    task automatic test_full_cycle();
        int travel;
        reset_settle();
        sen_i = 1'b1;
        repeat (3) step();
        n_checks++;
        if (dut_vec() !== V_DEAD) $display("FAIL full_dead_entry: dut=%b expected=%b", dut_vec(), V_DEAD);
        else n_pass++;
        repeat (2) step();
        sen_i = 1'b0;
        lc_i = 1'b0;
        step();
        n_checks++;
        if (dut_vec() !== V_DEAD) $display("FAIL full_dead_last: dut=%b expected=%b", dut_vec(), V_DEAD);
        else n_pass++;
        step();
        n_checks++;
        if (dut_vec() !== V_OPENING) $display("FAIL full_opening: dut=%b expected=%b", dut_vec(), V_OPENING);
        else n_pass++;
        travel = $urandom_range(3, 30);
        for (int i = 0; i < travel; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL full_travel_open[%0d]: dut=%b model=%b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        la_i = 1'b1;
        repeat (2) step();
        n_checks++;
        if (dut_vec() !== V_OPENING) $display("FAIL full_la_latency: dut=%b expected=%b", dut_vec(), V_OPENING);
        else n_pass++;
        step();
        n_checks++;
        if (dut_vec() !== V_HOLD) $display("FAIL full_open_hold: dut=%b expected=%b", dut_vec(), V_HOLD);
        else n_pass++;
        repeat (HOLD - 1) step();
        n_checks++;
        if (dut_vec() !== V_HOLD) $display("FAIL full_hold_last: dut=%b expected=%b", dut_vec(), V_HOLD);
        else n_pass++;
        step();
        n_checks++;
        if (dut_vec() !== V_DEAD) $display("FAIL full_hold_expire: dut=%b expected=%b", dut_vec(), V_DEAD);
        else n_pass++;
        la_i = 1'b0;
        repeat (DEAD - 1) step();
        n_checks++;
        if (dut_vec() !== V_DEAD) $display("FAIL full_dead_close: dut=%b expected=%b", dut_vec(), V_DEAD);
        else n_pass++;
        step();
        n_checks++;
        if (dut_vec() !== V_CLOSING) $display("FAIL full_closing: dut=%b expected=%b", dut_vec(), V_CLOSING);
        else n_pass++;
        travel = $urandom_range(3, 30);
        for (int i = 0; i < travel; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL full_travel_close[%0d]: dut=%b model=%b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        lc_i = 1'b1;
        repeat (2) step();
        n_checks++;
        if (dut_vec() !== V_CLOSING) $display("FAIL full_lc_latency: dut=%b expected=%b", dut_vec(), V_CLOSING);
        else n_pass++;
        step();
        n_checks++;
        if (dut_vec() !== V_CLOSED) $display("FAIL full_closed: dut=%b expected=%b", dut_vec(), V_CLOSED);
        else n_pass++;
    endtask

    task automatic test_reversal();
        int travel;
        reset_settle();
        lc_i = 1'b0;                       // drifted open: re-close
        repeat (7) step();
        n_checks++;
        if (dut_vec() !== V_CLOSING) $display("FAIL rev_closing: dut=%b expected=%b", dut_vec(), V_CLOSING);
        else n_pass++;
        travel = $urandom_range(2, 20);
        repeat (travel) step();
        sen_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            n_checks++;
            if (ma_o === 1'b1 && mc_o === 1'b1) $display("FAIL rev_overlap[%0d]: ma=%b mc=%b expected not both 1", i, ma_o, mc_o);
            else n_pass++;
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL rev_model[%0d]: dut=%b model=%b", i, dut_vec(), exp_vec());
            else n_pass++;
            if (i == 2) begin
                n_checks++;
                if (dut_vec() !== V_CLOSING) $display("FAIL rev_latency: dut=%b expected=%b", dut_vec(), V_CLOSING);
                else n_pass++;
            end
            if (i == 3) begin
                sen_i = 1'b0;
                n_checks++;
                if (dut_vec() !== V_DEAD) $display("FAIL rev_dead: dut=%b expected=%b", dut_vec(), V_DEAD);
                else n_pass++;
            end
            if (i == 6) begin
                n_checks++;
                if (dut_vec() !== V_DEAD) $display("FAIL rev_dead_last: dut=%b expected=%b", dut_vec(), V_DEAD);
                else n_pass++;
            end
            if (i == 7) begin
                n_checks++;
                if (dut_vec() !== V_OPENING) $display("FAIL rev_opening: dut=%b expected=%b", dut_vec(), V_OPENING);
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        reset_settle();
        go_opening();
        n_checks++;
        if (dut_vec() !== V_OPENING) $display("FAIL tmo_opening: dut=%b expected=%b", dut_vec(), V_OPENING);
        else n_pass++;
        repeat (TRAVEL - 1) step();
        n_checks++;
        if (dut_vec() !== V_OPENING) $display("FAIL tmo_last_travel: dut=%b expected=%b", dut_vec(), V_OPENING);
        else n_pass++;
        step();
        n_checks++;
        if (dut_vec() !== V_FAULT) $display("FAIL tmo_fault: dut=%b expected=%b", dut_vec(), V_FAULT);
        else n_pass++;
        fault_clr_i = 1'b1;
        step();
        fault_clr_i = 1'b0;
        step();
        n_checks++;
        if (dut_vec() !== V_FAULT) $display("FAIL tmo_clr_latency: dut=%b expected=%b", dut_vec(), V_FAULT);
        else n_pass++;
        step();
        n_checks++;
        if (dut_vec() !== V_CLOSED) $display("FAIL tmo_cleared: dut=%b expected=%b", dut_vec(), V_CLOSED);
        else n_pass++;
        go_opening();
        repeat (TRAVEL) step();
        n_checks++;
        if (dut_vec() !== V_FAULT) $display("FAIL tmo_fault2: dut=%b expected=%b", dut_vec(), V_FAULT);
        else n_pass++;
        se_i = 1'b1;
        fault_clr_i = 1'b1;
        repeat (6) step();
        n_checks++;
        if (dut_vec() !== V_FAULT) $display("FAIL tmo_clr_blocked_by_se: dut=%b expected=%b", dut_vec(), V_FAULT);
        else n_pass++;
        se_i = 1'b0;
        fault_clr_i = 1'b0;
        repeat (4) step();
        n_checks++;
        if (dut_vec() !== V_FAULT) $display("FAIL tmo_sticky: dut=%b expected=%b", dut_vec(), V_FAULT);
        else n_pass++;
    endtask

    task automatic test_estop();
        int hold;
        reset_settle();
        go_opening();
        repeat ($urandom_range(2, 20)) step();
        se_i = 1'b1;
        repeat (2) step();
        n_checks++;
        if (dut_vec() !== V_OPENING) $display("FAIL estop_latency: dut=%b expected=%b", dut_vec(), V_OPENING);
        else n_pass++;
        step();
        n_checks++;
        if (dut_vec() !== V_ESTOP) $display("FAIL estop_entry: dut=%b expected=%b", dut_vec(), V_ESTOP);
        else n_pass++;
        hold = $urandom_range(1, 15);
        repeat (hold) step();
        n_checks++;
        if (dut_vec() !== V_ESTOP) $display("FAIL estop_held: dut=%b expected=%b", dut_vec(), V_ESTOP);
        else n_pass++;
        se_i = 1'b0;
        lc_i = 1'b0;
        repeat (3) step();
        n_checks++;
        if (dut_vec() !== V_CLOSED) $display("FAIL estop_release: dut=%b expected=%b", dut_vec(), V_CLOSED);
        else n_pass++;
        step();
        n_checks++;
        if (dut_vec() !== V_DEAD) $display("FAIL estop_reclose_dead: dut=%b expected=%b", dut_vec(), V_DEAD);
        else n_pass++;
        repeat (DEAD) step();
        n_checks++;
        if (dut_vec() !== V_CLOSING) $display("FAIL estop_reclose_motor: dut=%b expected=%b", dut_vec(), V_CLOSING);
        else n_pass++;
    endtask

    task automatic test_conflict_ena();
        reset_settle();
        lc_i = 1'b0;
        repeat (7) step();
        repeat (3) step();
        la_i = 1'b1;
        lc_i = 1'b1;                       // lc alone would mean CLOSED
        repeat (3) step();
        n_checks++;
        if (dut_vec() !== V_FAULT) $display("FAIL conflict_fault: dut=%b expected=%b", dut_vec(), V_FAULT);
        else n_pass++;

        reset_settle();
        go_opening();
        lc_i = 1'b0;
        la_i = 1'b1;
        repeat (3) step();
        n_checks++;
        if (dut_vec() !== V_HOLD) $display("FAIL ena_hold_entry: dut=%b expected=%b", dut_vec(), V_HOLD);
        else n_pass++;
        repeat (4) step();
        // Frozen: pin activity here must never reach the FSM.
        ena = 1'b0;
        se_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                se_i = 1'b0;
                sen_i = 1'b1;
            end
            step();
            n_checks++;
            if (dut_vec() !== V_HOLD) $display("FAIL ena_frozen[%0d]: dut=%b expected=%b", i, dut_vec(), V_HOLD);
            else n_pass++;
        end
        sen_i = 1'b0;
        ena = 1'b1;
        // 4 hold cycles elapsed before the freeze, so 5 more remain.
        repeat (HOLD - 5) step();
        n_checks++;
        if (dut_vec() !== V_HOLD) $display("FAIL ena_counter_held: dut=%b expected=%b", dut_vec(), V_HOLD);
        else n_pass++;
        step();
        n_checks++;
        if (dut_vec() !== V_DEAD) $display("FAIL ena_hold_expire: dut=%b expected=%b", dut_vec(), V_DEAD);
        else n_pass++;
    endtask

    task automatic test_reset_mid_motion();
        reset_settle();
        go_opening();
        repeat (5) step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== V_CLOSED) $display("FAIL midreset_async: dut=%b expected=%b", dut_vec(), V_CLOSED);
        else n_pass++;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL midreset_restart[%0d]: dut=%b model=%b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        reset_settle();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0)  se_i  = ~se_i;
            if ($urandom_range(0, 9)  == 0)  sen_i = ~sen_i;
            if ($urandom_range(0, 14) == 0)  la_i  = ~la_i;
            if ($urandom_range(0, 14) == 0)  lc_i  = ~lc_i;
            fault_clr_i = ($urandom_range(0, 19) == 0);
            ena = ($urandom_range(0, 9) != 0);
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL random[%0d]: dut=%b model=%b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        ena = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_cycle();
        test_reversal();
        test_timeout();
        test_estop();
        test_conflict_ena();
        test_reset_mid_motion();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/door_sequencer.md
Name: door_sequencer

Overview:
Timed motion controller for one sliding-door motor. It replaces a bare one-step transition table with a sequenced door cycle: open on presence, hold open, auto-close, reverse on obstruction, motor dead-time between direction changes, travel timeout and emergency stop. It sits between the raw door sensors on ui and the motor-drive pins on uo. Moore-style outputs are decoded from the state register.

Parameters:
HOLD_CYCLES, 1000, cycles the door stays open after the last presence.
TRAVEL_MAX, 4000, maximum cycles in OPENING or CLOSING before a fault.
DEAD_CYCLES, 8, cycles with both motor outputs off before any motor start.
CNT_W, 16, phase-counter width; must hold max(HOLD_CYCLES, TRAVEL_MAX, DEAD_CYCLES).

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  when 0: state, counter and synchronisers are frozen and outputs hold
sen_i  in  1  presence sensor, 1 = person or obstruction
se_i  in  1  emergency stop, 1 = active
la_i  in  1  open limit switch
lc_i  in  1  closed limit switch
fault_clr_i  in  1  clears a latched fault
ma_o  out  1  motor open drive
mc_o  out  1  motor close drive
state_o  out  3  current state code
fault_o  out  1  1 while in FAULT
busy_o  out  1  1 in DEAD, OPENING, or CLOSING

Behaviour:
- Synchronisation: all five inputs pass a 2-flop synchroniser. A pin change is visible on state_o and the motor outputs 3 enabled cycles later (2 synchroniser cycles + 1 state register).
- State codes: CLOSED=0, DEAD=1, OPENING=2, OPEN_HOLD=3, CLOSING=4, ESTOP=5, FAULT=6. Code 7 is illegal; if reached, the next state is FAULT.
- Reset: state=CLOSED, counter=0, target=close, synchronisers=0. All outputs are 0.
- Output decode: ma_o = (state==OPENING); mc_o = (state==CLOSING). The two can never both be 1.
- Counter: a single CNT_W counter, cleared on every state change, increments each enabled cycle otherwise. It saturates at its maximum value.
- A 1-bit target register selects the direction taken on leaving DEAD.
- Transition priority in every state, highest first: se, then (la AND lc), then timeout, then limit switch, then sen.
- se=1 in any state except FAULT: next state is ESTOP.
- la=1 and lc=1 together while in DEAD, OPENING or CLOSING: next state is FAULT (inconsistent sensors).
- CLOSED:
  - sen=1: go to DEAD with target=open.
  - else lc=0: go to DEAD with target=close (re-closes a door that drifted open).
  - else stay.
- DEAD: after exactly DEAD_CYCLES cycles (counter==DEAD_CYCLES-1), go to OPENING if target=open, else CLOSING.
- OPENING:
  - la=1: go to OPEN_HOLD.
  - counter==TRAVEL_MAX-1 without la: go to FAULT.
- OPEN_HOLD:
  - sen=1 clears the counter.
  - counter==HOLD_CYCLES-1 with sen=0: go to DEAD with target=close.
- CLOSING:
  - lc=1: go to CLOSED.
  - else sen=1: go to DEAD with target=open (obstruction reversal).
  - timeout as in OPENING: go to FAULT.
  - lc and sen in the same cycle: lc wins.
- ESTOP: motors off. On se=0, go to CLOSED, which then re-evaluates sen and lc.
- FAULT: sticky, with fault_o=1 and motors off. fault_clr_i=1 with se=0 moves to CLOSED; otherwise stay. se does not leave FAULT.
- Reset mid-motion: motors drop immediately (asynchronous) and the FSM restarts in CLOSED.

Decomposition:
- Package door_pkg:
  - state enum and codes
  - TARGET_OPEN / TARGET_CLOSE constants
  - default parameter values
- Sub-module door_sync: parameterised-width 2-flop synchroniser with ena, instantiated once on a 5-bit bus {se, sen, la, lc, fault_clr}.

Test Plan:
- Parameters for all scenarios: HOLD=10, TRAVEL=50, DEAD=4.
- Reset idle: rst_n low, then high with lc=1 and other inputs 0 -> state_o=0, ma_o=mc_o=0 for 100 cycles.
- Full cycle: sen=1 for 5 cycles -> state 1 after 3 cycles, ma_o=1 4 cycles later. Assert la -> ma_o=0 after 3 cycles, state 3. Ten cycles after sen is seen low -> DEAD for 4 cycles, then mc_o=1. Assert lc -> state 0.
- Reversal: sen=1 while in CLOSING -> mc_o=0 after 3 cycles, state 1 for 4 cycles, then ma_o=1. No cycle has ma_o=mc_o=1.
- Timeout: OPENING with la held 0 -> after 50 cycles state 6, fault_o=1, ma_o=0. fault_clr_i pulse -> state 0; a later fault_clr with se=1 keeps FAULT.
- E-stop: se=1 mid-OPENING -> state 5, ma_o=0 after 3 cycles. Release se with lc=0 -> CLOSED, DEAD, then mc_o=1.
- Sensor conflict and ena: la=lc=1 during CLOSING -> FAULT. Separately, ena=0 for 20 cycles in OPEN_HOLD -> state_o and the counter are unchanged.
